// File: rtl/rggen_request_distributor.sv
// Routes one host register request to a one-hot selected slot and returns that slot's response.
// Optional ACCESS timeout: define RGGEN_REQUEST_DISTRIBUTOR_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a host request; decodes address on accept
// ACCESS   | one slot_valid bit held; waiting for that slot's ready
// RESPONSE | response presented to host until i_rsp_ready
module rggen_request_distributor #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic                     i_req_write,
    input  logic [BUS_WIDTH-1:0]     i_req_data,
    input  logic [BUS_WIDTH-1:0]     i_req_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_data,
    output logic [N-1:0]             o_slot_valid,
    output logic                     o_slot_write,
    output logic [BUS_WIDTH-1:0]     o_slot_data,
    output logic [BUS_WIDTH-1:0]     o_slot_strobe,
    input  logic [N-1:0]             i_slot_ready,
    input  logic [2*N-1:0]           i_slot_status,
    input  logic [N*BUS_WIDTH-1:0]   i_slot_data
);

    localparam int BYTES = BUS_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPONSE
    } state_e;

    state_e                   state;
    logic [ADDRESS_WIDTH-1:0] index;
    logic                     misaligned;
    logic [N-1:0]             decode_onehot;
    logic                     decode_hit;
    logic                     sel_ready;
    logic [1:0]               sel_status;
    logic [BUS_WIDTH-1:0]     sel_data;
    logic                     timeout_hit;

    assign index      = i_req_address >> LSB;
    assign misaligned = |(i_req_address & ADDRESS_WIDTH'(BYTES - 1));

    always_comb begin
        decode_onehot = '0;
        for (int i = 0; i < N; i++) begin
            decode_onehot[i] = (index == ADDRESS_WIDTH'(i));
        end
    end

    assign decode_hit = (|decode_onehot) && !misaligned;

    // Return path is an AND-OR over the held one-hot select; no select yields zero.
    always_comb begin
        sel_status = '0;
        sel_data   = '0;
        for (int i = 0; i < N; i++) begin
            sel_status = sel_status | (i_slot_status[2*i +: 2] & {2{o_slot_valid[i]}});
            sel_data   = sel_data | (i_slot_data[BUS_WIDTH*i +: BUS_WIDTH] & {BUS_WIDTH{o_slot_valid[i]}});
        end
    end

    assign sel_ready = |(i_slot_ready & o_slot_valid);

`ifdef RGGEN_REQUEST_DISTRIBUTOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] timeout_count;

    // Fires in the ACCESS cycle whose increment would reach the limit.
    assign timeout_hit = (timeout_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || state != ACCESS) begin
            timeout_count <= '0;
        end else if (!sel_ready) begin
            timeout_count <= timeout_count + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            o_req_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_status  <= 2'b00;
            o_rsp_data    <= '0;
            o_slot_valid  <= '0;
            o_slot_write  <= 1'b0;
            o_slot_data   <= '0;
            o_slot_strobe <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        o_req_ready   <= 1'b0;
                        o_slot_write  <= i_req_write;
                        o_slot_data   <= i_req_data;
                        o_slot_strobe <= i_req_strobe;
                        if (decode_hit) begin
                            o_slot_valid <= decode_onehot;
                            state        <= ACCESS;
                        end else begin
                            o_rsp_valid  <= 1'b1;
                            o_rsp_status <= 2'b11;
                            o_rsp_data   <= '0;
                            state        <= RESPONSE;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        o_rsp_status <= sel_status;
                        o_rsp_data   <= o_slot_write ? '0 : sel_data;
                        o_slot_valid <= '0;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESPONSE;
                    end else if (timeout_hit) begin
                        o_rsp_status <= 2'b10;
                        o_rsp_data   <= '0;
                        o_slot_valid <= '0;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESPONSE;
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_request_distributor.sv
// Bench for rggen_request_distributor: directed literal scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_rggen_request_distributor;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_req_valid;
    logic            o_req_ready;
    logic [AW-1:0]   i_req_address;
    logic            i_req_write;
    logic [BW-1:0]   i_req_data;
    logic [BW-1:0]   i_req_strobe;
    logic            o_rsp_valid;
    logic            i_rsp_ready;
    logic [1:0]      o_rsp_status;
    logic [BW-1:0]   o_rsp_data;
    logic [NS-1:0]   o_slot_valid;
    logic            o_slot_write;
    logic [BW-1:0]   o_slot_data;
    logic [BW-1:0]   o_slot_strobe;
    logic [NS-1:0]   i_slot_ready;
    logic [2*NS-1:0] i_slot_status;
    logic [NS*BW-1:0] i_slot_data;

    int n_checks = 0;
    int n_fail   = 0;

    rggen_request_distributor #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .N             (NS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_address(i_req_address),
        .i_req_write  (i_req_write),
        .i_req_data   (i_req_data),
        .i_req_strobe (i_req_strobe),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_status (o_rsp_status),
        .o_rsp_data   (o_rsp_data),
        .o_slot_valid (o_slot_valid),
        .o_slot_write (o_slot_write),
        .o_slot_data  (o_slot_data),
        .o_slot_strobe(o_slot_strobe),
        .i_slot_ready (i_slot_ready),
        .i_slot_status(i_slot_status),
        .i_slot_data  (i_slot_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: which phase the single in-flight transaction is in.
    int            m_phase = 0;   // 0 waiting for request, 1 at slot, 2 answering host
    int            m_idx = 0;
    logic [NS-1:0] m_slot = '0;
    logic          m_write = 1'b0;
    logic [BW-1:0] m_data = '0;
    logic [BW-1:0] m_strobe = '0;
    logic          m_rsp_valid = 1'b0;
    logic [1:0]    m_status = 2'b00;
    logic [BW-1:0] m_rdata = '0;
`ifdef RGGEN_REQUEST_DISTRIBUTOR_TIMEOUT_EN
    int            m_wait = 0;
`endif

    always begin
        int a;
        @(posedge i_clk);
        if (i_rst) begin
            m_phase = 0; m_slot = '0; m_write = 1'b0; m_data = '0; m_strobe = '0;
            m_rsp_valid = 1'b0; m_status = 2'b00; m_rdata = '0;
        end else if (m_phase == 0) begin
            if (i_req_valid) begin
                m_write  = i_req_write;
                m_data   = i_req_data;
                m_strobe = i_req_strobe;
                a = int'(i_req_address);
                if ((a % (BW / 8)) != 0 || (a / (BW / 8)) >= NS) begin
                    m_phase = 2; m_rsp_valid = 1'b1; m_status = 2'b11; m_rdata = '0;
                end else begin
                    m_idx = a / (BW / 8);
                    m_slot = '0;
                    m_slot[m_idx] = 1'b1;
                    m_phase = 1;
`ifdef RGGEN_REQUEST_DISTRIBUTOR_TIMEOUT_EN
                    m_wait = 0;
`endif
                end
            end
        end else if (m_phase == 1) begin
            if (i_slot_ready[m_idx]) begin
                m_status = i_slot_status[m_idx*2 +: 2];
                m_rdata  = m_write ? '0 : i_slot_data[m_idx*BW +: BW];
                m_slot = '0; m_rsp_valid = 1'b1; m_phase = 2;
            end
`ifdef RGGEN_REQUEST_DISTRIBUTOR_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_status = 2'b10; m_rdata = '0; m_slot = '0; m_rsp_valid = 1'b1; m_phase = 2;
                end
            end
`endif
        end else begin
            if (i_rsp_ready) begin
                m_rsp_valid = 1'b0; m_phase = 0;
            end
        end
        #1;
        check("m_req_ready", 64'(o_req_ready), 64'(m_phase == 0));
        check("m_rsp_valid", 64'(o_rsp_valid), 64'(m_rsp_valid));
        check("m_slot_valid", 64'(o_slot_valid), 64'(m_slot));
        check("m_slot_write", 64'(o_slot_write), 64'(m_write));
        check("m_slot_data", 64'(o_slot_data), 64'(m_data));
        check("m_slot_strobe", 64'(o_slot_strobe), 64'(m_strobe));
        if (m_rsp_valid) begin
            check("m_rsp_status", 64'(o_rsp_status), 64'(m_status));
            check("m_rsp_data", 64'(o_rsp_data), 64'(m_rdata));
        end
    end

    task automatic request(input logic [AW-1:0] addr, input logic wr,
                           input logic [BW-1:0] d, input logic [BW-1:0] s);
        i_req_valid = 1'b1; i_req_address = addr; i_req_write = wr;
        i_req_data = d; i_req_strobe = s;
    endtask

    task automatic finish_rsp();
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_address = '0; i_req_write = 1'b0;
        i_req_data = '0; i_req_strobe = '0; i_rsp_ready = 1'b0;
        i_slot_ready = '0; i_slot_status = '0; i_slot_data = '0;
        repeat (2) @(negedge i_clk);
        check("rst_req_ready", 64'(o_req_ready), 64'd1);
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("rst_slot_valid", 64'(o_slot_valid), 64'd0);
        check("rst_rsp_data", 64'(o_rsp_data), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Read slot 2, ready in first ACCESS cycle
        i_slot_data[2*BW +: BW] = 32'hDEADBEEF;
        i_slot_status[5:4] = 2'b00;
        i_slot_ready = 4'b0100;
        request(8'h08, 1'b0, 32'h0, 32'h0);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("rd_slot_valid", 64'(o_slot_valid), 64'h4);
        check("rd_req_ready", 64'(o_req_ready), 64'd0);
        @(negedge i_clk);
        check("rd_rsp_valid", 64'(o_rsp_valid), 64'd1);
        check("rd_rsp_data", 64'(o_rsp_data), 64'hDEADBEEF);
        check("rd_rsp_status", 64'(o_rsp_status), 64'd0);
        finish_rsp();
        check("rd_back_idle", 64'(o_req_ready), 64'd1);
        i_slot_ready = '0;

        // Write slot 1; read data must come back zero
        request(8'h04, 1'b1, 32'h12345678, 32'h0000FFFF);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("wr_slot_valid", 64'(o_slot_valid), 64'h2);
        check("wr_slot_write", 64'(o_slot_write), 64'd1);
        check("wr_slot_data", 64'(o_slot_data), 64'h12345678);
        check("wr_slot_strobe", 64'(o_slot_strobe), 64'h0000FFFF);
        i_slot_data[1*BW +: BW] = 32'hAAAA5555;
        i_slot_ready = 4'b0010;
        @(negedge i_clk);
        check("wr_rsp_valid", 64'(o_rsp_valid), 64'd1);
        check("wr_rsp_data", 64'(o_rsp_data), 64'd0);
        check("wr_rsp_status", 64'(o_rsp_status), 64'd0);
        finish_rsp();
        i_slot_ready = '0;

        // Out-of-range index and misaligned address
        for (int k = 0; k < 2; k++) begin
            request((k == 0) ? 8'h10 : 8'h05, 1'b0, 32'h0, 32'h0);
            @(negedge i_clk);
            i_req_valid = 1'b0;
            check("dec_rsp_valid", 64'(o_rsp_valid), 64'd1);
            check("dec_rsp_status", 64'(o_rsp_status), 64'd3);
            check("dec_rsp_data", 64'(o_rsp_data), 64'd0);
            check("dec_slot_valid", 64'(o_slot_valid), 64'd0);
            finish_rsp();
        end

        // Slave error held while host stalls
        i_slot_status[1:0] = 2'b10;
        i_slot_data[0 +: BW] = 32'h0BADF00D;
        i_slot_ready = 4'b0001;
        request(8'h00, 1'b0, 32'h0, 32'h0);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        i_slot_ready = '0;
        for (int k = 0; k < 5; k++) begin
            check("hold_rsp_valid", 64'(o_rsp_valid), 64'd1);
            check("hold_rsp_status", 64'(o_rsp_status), 64'd2);
            check("hold_rsp_data", 64'(o_rsp_data), 64'h0BADF00D);
            check("hold_req_ready", 64'(o_req_ready), 64'd0);
            @(negedge i_clk);
        end
        finish_rsp();
        check("hold_idle_ready", 64'(o_req_ready), 64'd1);
        check("hold_idle_rsp", 64'(o_rsp_valid), 64'd0);

        // Reset during ACCESS drops the transaction
        request(8'h0C, 1'b0, 32'h0, 32'h0);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("rstmid_slot_valid", 64'(o_slot_valid), 64'h8);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rstmid_slot_clear", 64'(o_slot_valid), 64'd0);
        check("rstmid_req_ready", 64'(o_req_ready), 64'd1);
        @(negedge i_clk);
        check("rstmid_no_rsp", 64'(o_rsp_valid), 64'd0);

`ifdef RGGEN_REQUEST_DISTRIBUTOR_TIMEOUT_EN
        begin
            int cnt;
            request(8'h04, 1'b0, 32'h0, 32'h0);
            @(negedge i_clk);
            i_req_valid = 1'b0;
            cnt = 0;
            while (o_slot_valid != '0 && cnt < 40) begin
                cnt++;
                @(negedge i_clk);
            end
            check("to_access_cycles", 64'(cnt), 64'd16);
            check("to_rsp_valid", 64'(o_rsp_valid), 64'd1);
            check("to_rsp_status", 64'(o_rsp_status), 64'd2);
            check("to_rsp_data", 64'(o_rsp_data), 64'd0);
            finish_rsp();

            i_slot_status[3:2] = 2'b00;
            i_slot_data[1*BW +: BW] = 32'hCAFE0016;
            request(8'h04, 1'b0, 32'h0, 32'h0);
            @(negedge i_clk);
            i_req_valid = 1'b0;
            repeat (15) @(negedge i_clk);
            i_slot_ready = 4'b0010;
            @(negedge i_clk);
            i_slot_ready = '0;
            check("to_edge_rsp_valid", 64'(o_rsp_valid), 64'd1);
            check("to_edge_status", 64'(o_rsp_status), 64'd0);
            check("to_edge_data", 64'(o_rsp_data), 64'hCAFE0016);
            finish_rsp();
        end
`endif

        // Randomized traffic; the model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            i_rst = ($urandom_range(0, 299) == 0);
            i_req_valid = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 7)
                i_req_address = AW'($urandom_range(0, NS - 1) * (BW / 8));
            else
                i_req_address = AW'($urandom_range(0, 255));
            i_req_write  = $urandom_range(0, 1);
            i_req_data   = $urandom;
            i_req_strobe = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
            for (int s = 0; s < NS; s++) begin
                i_slot_ready[s] = ($urandom_range(0, 2) == 0);
                i_slot_status[2*s +: 2] = $urandom_range(0, 1) ? 2'b10 : 2'b00;
                i_slot_data[s*BW +: BW] = $urandom;
            end
            i_rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge i_clk);
        end

        i_rst = 1'b0; i_req_valid = 1'b0; i_slot_ready = '1; i_rsp_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
